// File: rtl/cla_serial_add_ctrl.sv
// Digit-serial add/subtract controller.
// One 3-bit carry-lookahead slice is reused over NSLICE cycles to add or
// subtract WIDTH-bit operands, least-significant slice first. The carry
// between slices is held in carry_reg.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. in_valid/in_ready accept operands only in IDLE. out_valid
// stays high in DONE, with sum/cout/ovf held stable, until out_ready is
// seen high. Neither side may make its valid depend combinationally on the
// other side's ready.

// 3-bit carry-lookahead slice: all carries are formed directly from g/p/ci.
module cla_3b (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       ci,
  output logic [2:0] s,
  output logic       co
);
  logic [2:0] p;
  logic [2:0] g;
  logic       c1;
  logic       c2;

  // Propagate/generate and flat lookahead carries.
  always_comb begin
    p  = a ^ b;
    g  = a & b;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    co = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    s  = p ^ {c2, c1, ci};
  end
endmodule

module cla_serial_add_ctrl #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       dbg_state
);
  localparam int NSLICE = WIDTH / 3;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int MSB    = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic [KW-1:0]    k;

  logic [2:0]       sl_a;
  logic [2:0]       sl_b;
  logic [2:0]       sl_s;
  logic             sl_co;
  logic             last_slice;

  // Select the operand bits of slice k for the shared slice.
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (k == KW'(i)) begin
        sl_a = a_reg[3*i +: 3];
        sl_b = b_reg[3*i +: 3];
      end
    end
    last_slice = (k == KW'(NSLICE - 1));
  end

  cla_3b u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry_reg),
    .s  (sl_s),
    .co (sl_co)
  );

  // Controller FSM: latch operands, step the slice, hold the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      k         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1; cin only matters for addition.
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub ? 1'b1 : cin;
            k         <= '0;
            in_ready  <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NSLICE; i++) begin
            if (k == KW'(i)) begin
              sum_reg[3*i +: 3] <= sl_s;
            end
          end
          carry_reg <= sl_co;
          if (last_slice) begin
            // Overflow uses the inverted B so it is correct for subtraction too.
            cout      <= sl_co;
            ovf       <= (a_reg[MSB] == b_reg[MSB]) && (sl_s[2] != a_reg[MSB]);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign sum       = sum_reg;
  assign busy      = (state != IDLE);
  assign dbg_state = state;
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Bench for cla_serial_add_ctrl (WIDTH=12): table-driven operations, a
// backpressure sequence, a mid-operation reset and a back-to-back stream.
module tb_cla_serial_add_ctrl;
  localparam int W      = 12;
  localparam int NSLICE = W / 3;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic [1:0]   dbg_state;

  int errors;
  int checks;
  int cyc;
  int n_results;

  logic [W+1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[10];

  cla_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: {cout, ovf, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                         input logic xcin, input logic xsub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         c0;
    logic         v;
    bb   = xsub ? ~xb : xb;
    c0   = xsub ? 1'b1 : xcin;
    full = {1'b0, xa} + {1'b0, bb} + {{W{1'b0}}, c0};
    v    = (xa[W-1] == bb[W-1]) && (full[W-1] != xa[W-1]);
    return {full[W], v, full[W-1:0]};
  endfunction

  // Scoreboard: push on accepted operands, pop on delivered results.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      if (out_valid && out_ready) begin
        n_results++;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {18'd0, cout, ovf, sum}, 32'hFFFF_FFFF);
        end else begin
          logic [W+1:0] e;
          e = exp_q.pop_front();
          chk("sb_result", {18'd0, cout, ovf, sum}, {18'd0, e});
        end
      end
    end
  end

  // Wait for in_ready, present operands, let them be accepted, then scramble inputs.
  task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xcin, input logic xsub);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a = xa; b = xb; cin = xcin; sub = xsub; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  // Called right after the accepting edge: check latency, result, and drain it.
  task automatic finish_op(input string name, input logic [W-1:0] es,
                           input logic eco, input logic eov);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      chk("in_ready_low_run", {31'd0, in_ready}, 32'd0);
      n++;
      @(negedge clk);
    end
    chk({name, "_latency"}, n, NSLICE);
    if (!out_valid) return;
    chk({name, "_sum"}, {20'd0, sum}, {20'd0, es});
    chk({name, "_cout"}, {31'd0, cout}, {31'd0, eco});
    chk({name, "_ovf"}, {31'd0, ovf}, {31'd0, eov});
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic do_op(input string name, input vec_t v);
    start_op(v.a, v.b, v.cin, v.sub);
    finish_op(name, v.s, v.co, v.ov);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_sum"}, {20'd0, sum}, 32'd0);
    chk({name, "_cout"}, {31'd0, cout}, 32'd0);
    chk({name, "_ovf"}, {31'd0, ovf}, 32'd0);
  endtask

  initial begin
    int acc[3];
    int n;
    int base;
    logic [W+1:0] m;
    errors = 0; checks = 0; n_results = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    vecs[0] = '{a:12'hFFF, b:12'h001, cin:1'b0, sub:1'b0, s:12'h000, co:1'b1, ov:1'b0};
    vecs[1] = '{a:12'h7FF, b:12'h000, cin:1'b1, sub:1'b0, s:12'h800, co:1'b0, ov:1'b1};
    vecs[2] = '{a:12'h123, b:12'h456, cin:1'b1, sub:1'b0, s:12'h57A, co:1'b0, ov:1'b0};
    vecs[3] = '{a:12'h005, b:12'h007, cin:1'b1, sub:1'b1, s:12'hFFE, co:1'b0, ov:1'b0};
    vecs[4] = '{a:12'h800, b:12'h001, cin:1'b0, sub:1'b1, s:12'h7FF, co:1'b1, ov:1'b1};
    for (int i = 5; i < 10; i++) begin
      vecs[i].a   = W'($urandom);
      vecs[i].b   = W'($urandom);
      vecs[i].cin = 1'($urandom_range(0, 1));
      vecs[i].sub = 1'($urandom_range(0, 1));
      m = model(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      vecs[i].s  = m[W-1:0];
      vecs[i].ov = m[W];
      vecs[i].co = m[W+1];
    end

    // Reset.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_reset_state("reset");

    // Table-driven operations.
    for (int i = 0; i < 10; i++) do_op($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: hold result for 5 cycles while in_valid toggles.
    start_op(12'h123, 12'h456, 1'b0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("bp_latency", n, NSLICE);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_sum", {20'd0, sum}, 32'h579);
      chk("bp_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1;
    a = 12'h0AA; b = 12'h055; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_accept_busy", {31'd0, busy}, 32'd1);
    finish_op("bp_next", 12'h0FF, 1'b0, 1'b0);

    // Reset while the slice index is 2.
    start_op(12'hFFF, 12'h001, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_reset_state("midreset");
    start_op(12'h0AA, 12'h055, 1'b0, 1'b0);
    finish_op("after_reset", 12'h0FF, 1'b0, 1'b0);

    // Back-to-back stream with in_valid and out_ready held high.
    base = n_results;
    @(posedge clk); #1;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("b2b_in_ready_wait", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      acc[i] = cyc;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    end
    in_valid = 1'b0;
    n = 0;
    while (n_results < base + 3 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    chk("b2b_spacing_1", acc[1] - acc[0], NSLICE + 2);
    chk("b2b_spacing_2", acc[2] - acc[1], NSLICE + 2);
    chk("b2b_result_count", n_results - base, 3);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
